rvfi_mem_arbiter: RTL and testbench

RVFI_MEM_ARBITER -- requirements
Module: rvfi_mem_arbiter

---
 rtl/rvfi_mem_arbiter.sv | 84 ++++++++
 tb/tb_rvfi_mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rvfi_mem_arbiter.sv
// rvfi_mem_arbiter: arbitrates an instruction and a data requester onto one memory port,
// alternating grants on ties and flagging transfers that stall for TIMEOUT busy cycles.
module rvfi_mem_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [XLEN-1:0]   i_addr,
   output logic              i_ready,
   output logic [XLEN-1:0]   i_rdata,
   input  logic              d_valid,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN/8-1:0] d_wmask,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_ready,
   output logic [XLEN-1:0]   d_rdata,
   output logic              mem_valid,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_wmask,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ready,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              grant_d,
   output logic              timeout_err
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   state_t state, nxt;
   logic last_d, grant_d_q, err_q, busy, grant, pick_d, hit;
   logic [15:0] cnt;
   logic [16:0] cnt_inc;
   logic [XLEN-1:0] addr_q, wdata_q;
   logic [XLEN/8-1:0] wmask_q;
   assign busy    = state != IDLE;
   assign grant   = state == IDLE && (i_valid || d_valid);
   // on a tie the requester not served last wins; last_d=0 means I went last
   assign pick_d  = d_valid && (!i_valid || !last_d);
   assign cnt_inc = {1'b0, cnt} + 17'd1;
   // the stalled cycle that brings the count to TIMEOUT raises the flag at once
   assign hit     = busy && !mem_ready && cnt_inc == 17'(TIMEOUT);
   always_comb begin
      nxt = state;
      if (state == IDLE)
         nxt = pick_d ? BUSY_D : (i_valid ? BUSY_I : IDLE);
      else if (mem_ready)
         nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         grant_d_q <= 1'b0;
         err_q     <= 1'b0;
         cnt       <= '0;
         addr_q    <= '0;
         wmask_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state <= nxt;
         if (grant) begin
            addr_q    <= pick_d ? d_addr : i_addr;
            wmask_q   <= pick_d ? d_wmask : '0;
            wdata_q   <= pick_d ? d_wdata : '0;
            grant_d_q <= pick_d;
            cnt       <= '0;
         end else if (busy && !mem_ready && cnt != 16'hFFFF) begin
            cnt <= cnt_inc[15:0];
         end
         if (hit) err_q <= 1'b1;
         if (busy && mem_ready) last_d <= state == BUSY_D;
      end
   end
   assign mem_valid   = busy;
   assign mem_addr    = busy ? addr_q : '0;
   assign mem_wmask   = busy ? wmask_q : '0;
   assign mem_wdata   = busy ? wdata_q : '0;
   assign i_ready     = state == BUSY_I && mem_ready;
   assign d_ready     = state == BUSY_D && mem_ready;
   assign i_rdata     = i_ready ? mem_rdata : '0;
   assign d_rdata     = d_ready ? mem_rdata : '0;
   assign grant_d     = grant_d_q;
   assign timeout_err = err_q || hit;
endmodule

// File: tb/tb_rvfi_mem_arbiter.sv
// tb_rvfi_mem_arbiter: directed checks of grant order, latching, stalls, timeout and reset abandon.
module tb_rvfi_mem_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic i_valid = 0, d_valid = 0, mem_ready = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
   logic [3:0] d_wmask = 0;
   logic i_ready, d_ready, mem_valid, grant_d, timeout_err;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0] mem_wmask;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   rvfi_mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant_d(grant_d), .timeout_err(timeout_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      cyc();
      do_reset();
      #1;
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_grant_d", 32'(grant_d), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      chk("rst_i_ready", 32'(i_ready), 0);
      // single D write with immediate mem_ready
      d_valid = 1; d_addr = 32'h100; d_wmask = 4'hF; d_wdata = 32'hDEADBEEF;
      mem_ready = 1; mem_rdata = 32'hCAFE;
      #1;
      chk("t1_idle_mem_valid", 32'(mem_valid), 0);
      chk("t1_idle_d_ready", 32'(d_ready), 0);
      cyc();
      d_valid = 0;
      #1;
      chk("t1_mem_valid", 32'(mem_valid), 1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_wmask", 32'(mem_wmask), 32'hF);
      chk("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t1_d_ready", 32'(d_ready), 1);
      chk("t1_d_rdata", d_rdata, 32'hCAFE);
      chk("t1_i_ready", 32'(i_ready), 0);
      chk("t1_grant_d", 32'(grant_d), 1);
      cyc();
      chk("t1_after_mem_valid", 32'(mem_valid), 0);
      chk("t1_after_d_ready", 32'(d_ready), 0);
      chk("t1_after_d_rdata", d_rdata, 0);
      chk("t1_after_grant_d", 32'(grant_d), 1);
      chk("t1_after_i_ready", 32'(i_ready), 0);
      mem_ready = 0;
      // both requesting: D, I, D after reset
      do_reset();
      i_valid = 1; i_addr = 32'h200; d_valid = 1; d_addr = 32'h300; mem_ready = 1;
      for (int k = 0; k < 3; k++) begin
         logic ed;
         ed = (k != 1);
         cyc();
         if (k == 2) begin i_valid = 0; d_valid = 0; end
         #1;
         chk($sformatf("t2_grant_d_%0d", k), 32'(grant_d), 32'(ed));
         chk($sformatf("t2_addr_%0d", k), mem_addr, ed ? 32'h300 : 32'h200);
         chk($sformatf("t2_d_ready_%0d", k), 32'(d_ready), 32'(ed));
         chk($sformatf("t2_i_ready_%0d", k), 32'(i_ready), 32'(!ed));
         cyc();
         chk($sformatf("t2_idle_valid_%0d", k), 32'(mem_valid), 0);
      end
      // stalled I read
      mem_ready = 0; mem_rdata = 32'h13; i_valid = 1; i_addr = 32'h40;
      cyc();
      i_valid = 0;
      for (int c = 1; c <= 5; c++) begin
         chk($sformatf("t3_valid_%0d", c), 32'(mem_valid), 1);
         chk($sformatf("t3_addr_%0d", c), mem_addr, 32'h40);
         chk($sformatf("t3_wmask_%0d", c), 32'(mem_wmask), 0);
         chk($sformatf("t3_wdata_%0d", c), mem_wdata, 0);
         chk($sformatf("t3_i_ready_%0d", c), 32'(i_ready), 0);
         cyc();
      end
      mem_ready = 1;
      #1;
      chk("t3_i_ready", 32'(i_ready), 1);
      chk("t3_i_rdata", i_rdata, 32'h13);
      chk("t3_d_ready", 32'(d_ready), 0);
      chk("t3_grant_d", 32'(grant_d), 0);
      cyc();
      mem_ready = 0;
      // timeout with TIMEOUT=4
      do_reset();
      d_valid = 1; d_addr = 32'h400;
      cyc();
      d_valid = 0;
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("t4_err_%0d", c), 32'(timeout_err), 32'(c >= 4));
         chk($sformatf("t4_valid_%0d", c), 32'(mem_valid), 1);
         cyc();
      end
      mem_ready = 1;
      #1;
      chk("t4_d_ready", 32'(d_ready), 1);
      cyc();
      mem_ready = 0;
      #1;
      chk("t4_err_sticky", 32'(timeout_err), 1);
      chk("t4_idle_valid", 32'(mem_valid), 0);
      // reset in 2nd BUSY_D cycle
      do_reset();
      d_valid = 1; d_addr = 32'h500;
      cyc();
      d_valid = 0;
      chk("t5_busy_valid", 32'(mem_valid), 1);
      cyc();
      reset = 1;
      #1;
      chk("t5_rst_d_ready", 32'(d_ready), 0);
      cyc();
      reset = 0; mem_ready = 1;
      #1;
      chk("t5_mem_valid", 32'(mem_valid), 0);
      chk("t5_d_ready", 32'(d_ready), 0);
      chk("t5_timeout", 32'(timeout_err), 0);
      chk("t5_grant_d", 32'(grant_d), 0);
      cyc();
      chk("t5_later_d_ready", 32'(d_ready), 0);
      chk("t5_later_valid", 32'(mem_valid), 0);
      mem_ready = 0;
      // d_valid dropped mid-transfer with fields changed
      d_valid = 1; d_addr = 32'h600;
      cyc();
      cyc();
      d_valid = 0; d_addr = 32'h777;
      #1;
      chk("t6_addr_c2", mem_addr, 32'h600);
      chk("t6_valid_c2", 32'(mem_valid), 1);
      cyc();
      mem_ready = 1;
      #1;
      chk("t6_d_ready", 32'(d_ready), 1);
      chk("t6_addr_c3", mem_addr, 32'h600);
      cyc();
      mem_ready = 0;
      #1;
      chk("t6_idle_valid", 32'(mem_valid), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
